// File: rtl/fft_peak_detector.sv
// Peak-power bin tracker on the FFT output stream: one result beat per frame
// carrying the max re^2+im^2, its bin index and a frame-length error flag.
module fft_peak_detector #(
    parameter int unsigned NFFT_LOG2 = 10,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned USER_W    = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [2*DATA_W-1:0]   s_axis_data_tdata,
    input  logic [USER_W-1:0]     s_axis_data_tuser,
    input  logic                  s_axis_data_tvalid,
    output logic                  s_axis_data_tready,
    input  logic                  s_axis_data_tlast,
    output logic [47:0]           m_axis_peak_tdata,
    output logic                  m_axis_peak_tuser,
    output logic                  m_axis_peak_tvalid,
    input  logic                  m_axis_peak_tready,
    output logic [15:0]           frame_count
);

    localparam int unsigned POW_W = 2 * DATA_W;
    localparam int unsigned CNT_W = NFFT_LOG2 + 1;
    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(1 << NFFT_LOG2);
    localparam logic [CNT_W-1:0] CNT_SAT   = FRAME_LEN + CNT_W'(1);

    logic                     accept_c;
    logic signed [DATA_W-1:0] re_c;
    logic signed [DATA_W-1:0] im_c;
    logic signed [POW_W-1:0]  re_sq_c;
    logic signed [POW_W-1:0]  im_sq_c;
    logic [CNT_W-1:0]         cnt_inc_c;
    logic [POW_W-1:0]         power_c;
    logic                     unused_tuser_hi;

    logic                 valid_s1;
    logic                 last_s1;
    logic                 err_s1;
    logic [POW_W-1:0]     re_sq_s1;
    logic [POW_W-1:0]     im_sq_s1;
    logic [NFFT_LOG2-1:0] idx_s1;
    logic [CNT_W-1:0]     beat_cnt;

    logic                 last_s2;
    logic                 err_s2;
    logic                 seen_beat;
    logic [POW_W-1:0]     max_pow;
    logic [NFFT_LOG2-1:0] max_idx;

    // Stall while a tlast is in flight or a result waits: one result outstanding at most.
    assign s_axis_data_tready = ~areset & ~m_axis_peak_tvalid & ~last_s1 & ~last_s2;
    assign accept_c           = s_axis_data_tvalid & s_axis_data_tready;

    assign re_c      = s_axis_data_tdata[DATA_W-1:0];
    assign im_c      = s_axis_data_tdata[2*DATA_W-1:DATA_W];
    assign re_sq_c   = POW_W'(re_c) * POW_W'(re_c);
    assign im_sq_c   = POW_W'(im_c) * POW_W'(im_c);
    assign cnt_inc_c = (beat_cnt == CNT_SAT) ? beat_cnt : beat_cnt + CNT_W'(1);
    assign power_c   = re_sq_s1 + im_sq_s1;

    assign unused_tuser_hi = ^s_axis_data_tuser[USER_W-1:NFFT_LOG2];

    // Stage 1: squares, index and frame-length verdict captured on accept.
    always_ff @(posedge aclk) begin
        if (areset) begin
            valid_s1 <= 1'b0;
            last_s1  <= 1'b0;
            err_s1   <= 1'b0;
            re_sq_s1 <= '0;
            im_sq_s1 <= '0;
            idx_s1   <= '0;
            beat_cnt <= '0;
        end else begin
            valid_s1 <= accept_c;
            last_s1  <= accept_c & s_axis_data_tlast;
            if (accept_c) begin
                re_sq_s1 <= re_sq_c;
                im_sq_s1 <= im_sq_c;
                idx_s1   <= s_axis_data_tuser[NFFT_LOG2-1:0];
                err_s1   <= (cnt_inc_c != FRAME_LEN);
                beat_cnt <= s_axis_data_tlast ? '0 : cnt_inc_c;
            end
        end
    end

    // Stage 2: running max; first beat loads unconditionally, ties keep the earlier bin.
    always_ff @(posedge aclk) begin
        if (areset) begin
            last_s2   <= 1'b0;
            err_s2    <= 1'b0;
            seen_beat <= 1'b0;
            max_pow   <= '0;
            max_idx   <= '0;
        end else begin
            last_s2 <= last_s1;
            if (valid_s1) begin
                err_s2    <= err_s1;
                seen_beat <= ~last_s1;
                if (!seen_beat || (power_c > max_pow)) begin
                    max_pow <= power_c;
                    max_idx <= idx_s1;
                end
            end
        end
    end

    // Stage 3: result register and output handshake.
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axis_peak_tvalid <= 1'b0;
            m_axis_peak_tdata  <= '0;
            m_axis_peak_tuser  <= 1'b0;
            frame_count        <= '0;
        end else begin
            if (m_axis_peak_tvalid && m_axis_peak_tready) begin
                m_axis_peak_tvalid <= 1'b0;
                frame_count        <= frame_count + 16'(1);
            end
            if (last_s2) begin
                m_axis_peak_tvalid <= 1'b1;
                m_axis_peak_tdata  <= {16'(max_idx), 32'(max_pow)};
                m_axis_peak_tuser  <= err_s2;
            end
        end
    end

endmodule

// File: doc/fft_peak_detector.md
Name: fft_peak_detector

Overview:
- AXI4-Stream sink on the output side of the FFT core. Consumes the complex spectrum stream: real in tdata[15:0], imag in tdata[31:16], bin index on tuser, frame end on tlast.
- Computes power re²+im² per bin and tracks the maximum-power bin over each frame.
- Emits one result beat per frame: peak power, peak bin index and a frame-length error flag.
- Sits between the FFT core's m_axis_data port and the downstream control/readout logic.

Parameters:
NFFT_LOG2, 10, log2 of the expected frame length (1024 bins)
DATA_W, 16, width of each signed real/imag component
USER_W, 16, width of the tuser bin-index field

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous reset, active-high
s_axis_data_tdata  in  32  {imag[31:16], real[15:0]}, two's complement
s_axis_data_tuser  in  USER_W  bin index; bits [NFFT_LOG2-1:0] used, rest ignored
s_axis_data_tvalid  in  1  input beat valid
s_axis_data_tready  out  1  input beat accepted when tvalid&tready
s_axis_data_tlast  in  1  last bin of frame
m_axis_peak_tdata  out  48  {bin_index[47:32] zero-extended, peak_power[31:0] unsigned}
m_axis_peak_tuser  out  1  frame-length error flag for this result
m_axis_peak_tvalid  out  1  result valid
m_axis_peak_tready  in  1  result accepted when tvalid&tready
frame_count  out  16  number of results delivered; wraps 0xFFFF->0

Behaviour:
- Reset (areset=1 at a rising edge):
  - m_axis_peak_tvalid=0, m_axis_peak_tdata=0, m_axis_peak_tuser=0, frame_count=0.
  - Pipeline valid bits, running max, max index, beat counter and first-beat flag are cleared.
  - s_axis_data_tready=0 during the reset cycle.
  - Reset mid-frame discards the partial frame. No result is emitted for it. The next accepted beat starts a new frame.
- Pipeline:
  - Stage 1, registered on accept: re², im², index, tlast, valid.
  - Stage 2: power = re²+im² as 32-bit unsigned, compared to the running max and updated.
  - Stage 3: result register.
  - Worst case (-32768, -32768) gives power 0x8000_0000, which fits with no overflow.
- Latency: tlast beat accepted in cycle 0 -> m_axis_peak_tvalid=1 in cycle 3.
- Running max rules:
  - The first beat of each frame unconditionally loads power and index.
  - Later beats replace the stored max only if power is strictly greater. On ties the lowest-arrival (first) bin wins.
  - An all-zero frame reports power 0 and the index of its first beat.
- Frame length check:
  - The beat counter counts accepted beats in the frame and saturates at 2^NFFT_LOG2+1.
  - At tlast, m_axis_peak_tuser=1 if count != 2^NFFT_LOG2.
  - A frame is closed only by tlast; a missing tlast simply extends the frame.
  - The counter and first-beat flag re-arm the cycle after tlast is accepted.
- Input flow control: s_axis_data_tready = ~areset & ~m_axis_peak_tvalid & ~last_s1 & ~last_s2. Consequences:
  - Input stalls while a tlast is in flight and while a result waits.
  - At most one result is ever outstanding.
  - Minimum back-to-back frame overhead is 3 stall cycles with m_axis_peak_tready held high.
- Output handshake:
  - m_axis_peak_tvalid holds with stable tdata/tuser until tready=1.
  - The beat clears on the accept edge, and frame_count increments on that same edge.
  - tready may be high before tvalid, and the result is then consumed in its first valid cycle.
- Single-beat frame (tlast on the first beat): the result is that beat's power/index with tuser=1, since length 1 != 2^NFFT_LOG2.
- Beats arriving with tvalid=0 or tready=0 do not advance the counter or the pipeline. Pipeline stages advance only on valid data.

Test Plan:
1. Impulse: 1024 beats all 0 except bin 5 = real 0x0100, imag 0x0000; tlast on beat 1023 -> result power 0x0001_0000, index 5, tuser=0, valid 3 cycles after tlast accept, frame_count=1.
2. Tie and sign: bins 10 and 700 both (re=-300, im=400), others 0 -> power 250000 (0x0003_D090), index 10. Full-scale bin 3 (re=im=-32768) -> power 0x8000_0000, index 3.
3. Length errors:
   - tlast on beat 511 -> tuser=1, peak from the first 512 bins only.
   - A frame of 1030 beats -> tuser=1.
   - The following correct 1024-beat frame -> tuser=0.
4. Backpressure:
   - Hold m_axis_peak_tready=0 for 20 cycles after the result appears -> tvalid and tdata stable, s_axis_data_tready=0 throughout, no input beats lost.
   - Release -> frame_count increments once, input resumes the next cycle.
5. Random input tvalid gaps (≈30% idle) over 4 frames with known peaks -> all 4 results match the model, frame_count=4.
6. Reset mid-frame: assert areset at beat 400 of a frame. Then send a full frame with its peak at bin 900 -> exactly one result (index 900, tuser=0), with no residue from the aborted frame.
